// File: rtl/bsg_bus_pack_buffered.sv
// Subword pack/unpack datapath feeding an els_p-deep result FIFO.
// valid/ready on the request side, valid/yumi on the result side.
module bsg_bus_pack_buffered #(
    parameter int unsigned width_p       = 64,
    parameter int unsigned unit_width_p  = 8,
    parameter int unsigned els_p         = 2,
    localparam int unsigned units_lp      = width_p / unit_width_p,
    localparam int unsigned sel_width_lp  = (units_lp > 1) ? $clog2(units_lp) : 1,
    localparam int unsigned size_width_lp = $clog2(sel_width_lp + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [width_p-1:0]       data_i,
    input  logic [sel_width_lp-1:0]  sel_i,
    input  logic [size_width_lp-1:0] size_i,
    input  logic                     mode_i,
    input  logic                     signed_i,
    output logic                     v_o,
    input  logic                     yumi_i,
    output logic [width_p-1:0]       data_o,
    output logic [units_lp-1:0]      mask_o,
    output logic                     misaligned_o
);

    localparam int unsigned entry_w_lp = width_p + units_lp + 1;
    localparam int unsigned ptr_w_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp   = $clog2(els_p + 1);

    // ---------------- datapath ----------------
    logic [sel_width_lp-1:0] low_mask, aligned, src_idx, unit_idx;
    int unsigned             eff_size;
    logic [width_p-1:0]      rot, pack_data, unpack_data;
    logic [units_lp-1:0]     pack_mask;
    logic                    sub_msb;
    logic [entry_w_lp-1:0]   entry_c;

    always_comb begin
        eff_size = 32'(size_i);
        if (eff_size > sel_width_lp) begin
            eff_size = sel_width_lp;
        end
        low_mask = '0;
        for (int unsigned i = 0; i < sel_width_lp; i++) begin
            low_mask[i] = (i < eff_size);
        end
        aligned     = sel_i & ~low_mask;
        rot         = '0;
        pack_data   = '0;
        unpack_data = '0;
        pack_mask   = '0;
        sub_msb     = 1'b0;
        src_idx     = '0;
        unit_idx    = '0;

        // Unit-granular rotate right by the aligned offset
        for (int unsigned u = 0; u < units_lp; u++) begin
            src_idx = sel_width_lp'(u) + aligned;
            rot[u*unit_width_p +: unit_width_p] = data_i[src_idx*unit_width_p +: unit_width_p];
        end

        // The subword's top unit sits at index 2^s-1 of the rotated bus
        for (int unsigned u = 0; u < units_lp; u++) begin
            unit_idx = sel_width_lp'(u);
            if (unit_idx == low_mask) begin
                sub_msb = rot[u*unit_width_p + unit_width_p - 1];
            end
        end

        for (int unsigned u = 0; u < units_lp; u++) begin
            unit_idx = sel_width_lp'(u);
            pack_data[u*unit_width_p +: unit_width_p] =
                rot[(unit_idx & low_mask)*unit_width_p +: unit_width_p];
            pack_mask[u] = ((unit_idx & ~low_mask) == aligned);
            unpack_data[u*unit_width_p +: unit_width_p] =
                ((unit_idx & ~low_mask) == '0) ? rot[u*unit_width_p +: unit_width_p]
                                               : {unit_width_p{signed_i & sub_msb}};
        end

        entry_c = {(sel_i != aligned),
                   mode_i ? {units_lp{1'b1}} : pack_mask,
                   mode_i ? unpack_data : pack_data};
    end

    // ---------------- result FIFO ----------------
    logic [entry_w_lp-1:0] mem_q [els_p];
    logic [entry_w_lp-1:0] mem_d [els_p];
    logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic                  v_q, v_d, ready_q, ready_d;
    logic [entry_w_lp-1:0] head_q, head_d;
    logic                  enq, deq;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Head entry is re-registered from the post-update FIFO so outputs come from flops
    always_comb begin
        enq      = v_i & ready_q;
        deq      = yumi_i & v_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = entry_c;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (deq) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
        v_d     = (count_d != '0);
        ready_d = (count_d != cnt_w_lp'(els_p));
        head_d  = v_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int unsigned i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            v_q      <= 1'b0;
            ready_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            v_q      <= v_d;
            ready_q  <= ready_d;
            head_q   <= head_d;
        end
    end

    assign ready_o      = ready_q;
    assign v_o          = v_q;
    assign data_o       = head_q[width_p-1:0];
    assign mask_o       = head_q[width_p +: units_lp];
    assign misaligned_o = head_q[entry_w_lp-1];

    // Simulation-time parameter and protocol checks
    always_ff @(posedge clk_i) begin
        assert ((width_p & (width_p - 1)) == 0) else $error("width_p must be a power of 2");
        assert ((unit_width_p & (unit_width_p - 1)) == 0) else $error("unit_width_p must be a power of 2");
        assert (unit_width_p > 1) else $error("unit_width_p must exceed 1");
        assert (els_p >= 1) else $error("els_p must be at least 1");
        if (reset_n_i) begin
            assert (!(yumi_i && !v_q)) else $error("yumi_i asserted while v_o is low");
        end
    end

endmodule

// File: tb/tb_bsg_bus_pack_buffered.sv
// Bench for bsg_bus_pack_buffered: directed vector table, handshake corner
// sequences and a random stream checked against an independent model.
module tb_bsg_bus_pack_buffered;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        v_i, ready_o, mode_i, signed_i, v_o, yumi_i, misaligned_o;
    logic [63:0] data_i, data_o;
    logic [2:0]  sel_i;
    logic [1:0]  size_i;
    logic [7:0]  mask_o;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  m;
        logic        mis;
    } exp_t;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  sel;
        logic [1:0]  size;
        logic        mode;
        logic        sgn;
        logic [63:0] exp_d;
        logic [7:0]  exp_m;
        logic        exp_mis;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    bsg_bus_pack_buffered #(.width_p(64), .unit_width_p(8), .els_p(2)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
        .data_i(data_i), .sel_i(sel_i), .size_i(size_i), .mode_i(mode_i),
        .signed_i(signed_i), .v_o(v_o), .yumi_i(yumi_i), .data_o(data_o),
        .mask_o(mask_o), .misaligned_o(misaligned_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] d, input logic [2:0] sel,
                                   input logic [1:0] size, input logic mode, input logic sgn);
        exp_t        e;
        int unsigned n, nb, a;
        logic [127:0] dd;
        logic [63:0] r, sub, lowbits;
        n  = 1 << size;
        nb = n * 8;
        a  = (32'(sel) / n) * n;
        dd = {d, d};
        r  = 64'(dd >> (a * 8));
        lowbits = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
        sub = r & lowbits;
        if (!mode) begin
            e.d = '0;
            for (int i = 0; i < 64 / nb; i++) e.d |= sub << (i * nb);
            e.m = 8'(((16'd1 << n) - 16'd1) << a);
        end else begin
            e.d = (sgn && nb < 64 && sub[nb-1]) ? (sub | ~lowbits) : sub;
            e.m = 8'hFF;
        end
        e.mis = (32'(sel) != a);
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on dequeue
    always @(negedge clk) begin
        if (reset_n_i) begin
            if (v_o && yumi_i) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 64'(v_o), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data", data_o, e.d);
                    check("sb_mask", 64'(mask_o), 64'(e.m));
                    check("sb_misaligned", 64'(misaligned_o), 64'(e.mis));
                end
            end
            if (v_i && ready_o) sb.push_back(model(data_i, sel_i, size_i, mode_i, signed_i));
        end
    end

    // Called at posedge+1; holds the request until accepted
    task automatic send(input logic [63:0] d, input logic [2:0] sel, input logic [1:0] size,
                        input logic mode, input logic sgn);
        int waits = 0;
        data_i = d; sel_i = sel; size_i = size; mode_i = mode; signed_i = sgn; v_i = 1'b1;
        @(negedge clk);
        while (!ready_o && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!ready_o) check("send_timeout", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        v_i = 1'b0;
    endtask

    task automatic send_rand();
        send({$urandom, $urandom}, 3'($urandom_range(7)), 2'($urandom_range(3)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    initial begin
        logic prod_done;
        vecs[0] = '{64'h0000_0000_0000_AB00, 3'd1, 2'd0, 1'b0, 1'b0, 64'hABAB_ABAB_ABAB_ABAB, 8'h02, 1'b0};
        vecs[1] = '{64'h0000_8001_0000_0000, 3'd4, 2'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 8'hFF, 1'b0};
        vecs[2] = '{64'h0000_8001_0000_0000, 3'd4, 2'd1, 1'b1, 1'b0, 64'h0000_0000_0000_8001, 8'hFF, 1'b0};
        vecs[3] = '{64'h1122_3344_5566_7788, 3'd3, 2'd2, 1'b0, 1'b0, 64'h5566_7788_5566_7788, 8'h0F, 1'b1};
        vecs[4] = '{64'h1122_3344_5566_7788, 3'd5, 2'd3, 1'b0, 1'b0, 64'h1122_3344_5566_7788, 8'hFF, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0001, 3'd0, 2'd3, 1'b1, 1'b1, 64'h8000_0000_0000_0001, 8'hFF, 1'b0};
        vecs[6] = '{64'h8000_0000_0000_0000, 3'd7, 2'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 8'hFF, 1'b0};
        vecs[7] = '{64'hBEEF_0000_0000_0000, 3'd6, 2'd1, 1'b0, 1'b0, 64'hBEEF_BEEF_BEEF_BEEF, 8'hC0, 1'b0};
        vecs[8] = '{64'hF234_5678_0000_0000, 3'd4, 2'd2, 1'b1, 1'b0, 64'h0000_0000_F234_5678, 8'hFF, 1'b0};
        vecs[9] = '{64'h1122_3344_5566_7788, 3'd0, 2'd0, 1'b0, 1'b1, 64'h8888_8888_8888_8888, 8'h01, 1'b0};

        reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
        sel_i = '0; size_i = '0; mode_i = 1'b0; signed_i = 1'b0;
        #23;
        check("rst_v_o", 64'(v_o), 64'd0);
        check("rst_data_o", data_o, 64'd0);
        check("rst_mask_o", 64'(mask_o), 64'd0);
        check("rst_misaligned_o", 64'(misaligned_o), 64'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        @(negedge clk);
        check("rst_ready_o", 64'(ready_o), 64'd1);
        @(posedge clk); #1;

        // Directed vector table
        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].sel, vecs[i].size, vecs[i].mode, vecs[i].sgn);
            yumi_i = v_o;
            @(negedge clk);
            check($sformatf("vec%0d_v_o", i), 64'(v_o), 64'd1);
            check($sformatf("vec%0d_data", i), data_o, vecs[i].exp_d);
            check($sformatf("vec%0d_mask", i), 64'(mask_o), 64'(vecs[i].exp_m));
            check($sformatf("vec%0d_mis", i), 64'(misaligned_o), 64'(vecs[i].exp_mis));
            @(posedge clk); #1;
            yumi_i = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_empty", i), 64'(v_o), 64'd0);
            @(posedge clk); #1;
        end

        // Backpressure: three back-to-back requests into a 2-deep buffer
        data_i = 64'h0102_0304_0506_0708; sel_i = 3'd2; size_i = 2'd1; mode_i = 1'b0; v_i = 1'b1;
        @(negedge clk); check("bp_ready_a", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        data_i = 64'hF0E0_D0C0_B0A0_9080; sel_i = 3'd5; size_i = 2'd0; mode_i = 1'b1; signed_i = 1'b1;
        @(negedge clk); check("bp_ready_b", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        data_i = 64'hCAFE_BABE_DEAD_BEEF; sel_i = 3'd4; size_i = 2'd2; mode_i = 1'b0;
        @(negedge clk);
        check("bp_full_ready", 64'(ready_o), 64'd0);
        check("bp_full_v_o", 64'(v_o), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); check("bp_held_ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        yumi_i = 1'b1;
        @(negedge clk); check("bp_deq_ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_after_deq_ready", 64'(ready_o), 64'd1);
        check("bp_after_deq_v_o", 64'(v_o), 64'd1);
        @(posedge clk); #1;
        v_i = 1'b0;
        @(negedge clk);
        check("cc_count1_v_o", 64'(v_o), 64'd1);
        check("cc_count1_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        yumi_i = 1'b0;
        @(negedge clk);
        check("bp_drained_v_o", 64'(v_o), 64'd0);
        check("bp_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Random stream with a random consumer
        prod_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 100; k++) begin
                    send_rand();
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                prod_done = 1'b1;
            end
            begin
                int cyc = 0;
                while ((!prod_done || sb.size() != 0) && cyc < 20000) begin
                    @(posedge clk); #1;
                    yumi_i = v_o && ($urandom_range(3) != 0);
                    cyc++;
                end
                yumi_i = 1'b0;
                if (cyc >= 20000) check("stream_timeout", 64'(sb.size()), 64'd0);
            end
        join
        @(negedge clk);
        check("stream_empty_v_o", 64'(v_o), 64'd0);
        @(posedge clk); #1;

        // Asynchronous reset with two entries held
        send_rand();
        send_rand();
        @(negedge clk);
        check("ar_full_v_o", 64'(v_o), 64'd1);
        check("ar_full_ready", 64'(ready_o), 64'd0);
        #2;
        reset_n_i = 1'b0;
        sb.delete();
        #1;
        check("ar_v_o_immediate", 64'(v_o), 64'd0);
        check("ar_data_cleared", data_o, 64'd0);
        check("ar_mask_cleared", 64'(mask_o), 64'd0);
        @(posedge clk); #1;
        reset_n_i = 1'b1;
        @(negedge clk);
        check("ar_ready_after", 64'(ready_o), 64'd1);
        check("ar_no_stale_v_o", 64'(v_o), 64'd0);
        @(posedge clk); #1;
        send(vecs[7].d, vecs[7].sel, vecs[7].size, vecs[7].mode, vecs[7].sgn);
        yumi_i = v_o;
        @(negedge clk);
        check("ar_post_v_o", 64'(v_o), 64'd1);
        check("ar_post_data", data_o, vecs[7].exp_d);
        @(posedge clk); #1;
        yumi_i = 1'b0;
        @(negedge clk);
        check("ar_post_empty", 64'(v_o), 64'd0);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
